// File: rtl/intr_ctrl.sv
// Purpose : vectored 4-line interrupt controller with edge detect, mask, fixed priority and return-address save.
// Latency : an irq rising edge sampled at edge k gives pc_load in the cycle after edge k+1; RETURN lasts one cycle.
// Backpressure: none; requests accumulate in the pending register while masked, disabled or in service.
//
// Ports:
//   clk, reset       clock and synchronous active-low reset
//   irq[3:0]         rising-edge requests, irq[0] highest priority
//   ien              global interrupt enable
//   mask_we, mask_in mask register write (1 = line enabled)
//   pc_next          return address offered by the CPU
//   reti             return-from-interrupt strobe
//   pc_load          PC load strobe (ACK and RETURN only)
//   pc_vector        service vector in ACK, saved return address in RETURN, else 0
//   interruption     selects the interrupt flag bank (SERVICE and RETURN)
//   irq_id           index of the interrupt in service
//   pending, mask    pending-request and mask registers
//   busy             FSM not in IDLE
module intr_ctrl #(
    parameter int                 WIDTH    = 10,
    parameter logic [WIDTH-1:0]   VEC_BASE = 10'h3F0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       irq,
    input  logic             ien,
    input  logic             mask_we,
    input  logic [3:0]       mask_in,
    input  logic [WIDTH-1:0] pc_next,
    input  logic             reti,
    output logic             pc_load,
    output logic [WIDTH-1:0] pc_vector,
    output logic             interruption,
    output logic [1:0]       irq_id,
    output logic [3:0]       pending,
    output logic [3:0]       mask,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACK     = 2'd1,
        ST_SERVICE = 2'd2,
        ST_RETURN  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_irq_q;
    logic [3:0]       r_pending;
    logic [3:0]       r_mask;
    logic [1:0]       r_irq_id;
    logic [WIDTH-1:0] r_ret_pc;

    logic [3:0]       w_rise;
    logic [3:0]       w_req;
    logic [1:0]       w_winner;
    logic             w_accept;
    logic [3:0]       w_clr;
    logic [WIDTH-1:0] w_vec;

    // Request detection and arbitration use only registered state, so no
    // combinational path exists from irq to pc_load.
    always_comb begin
        w_rise   = irq & ~r_irq_q;
        w_req    = r_pending & r_mask;
        w_winner = 2'd0;
        if (w_req[0])      w_winner = 2'd0;
        else if (w_req[1]) w_winner = 2'd1;
        else if (w_req[2]) w_winner = 2'd2;
        else if (w_req[3]) w_winner = 2'd3;
        w_accept = (r_state == ST_IDLE) && ien && (|w_req);
        w_clr    = w_accept ? (4'b0001 << w_winner) : 4'b0000;
        // Wraps modulo 2^WIDTH by construction.
        w_vec    = VEC_BASE + WIDTH'({r_irq_id, 2'b00});
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_irq_q   <= 4'b0000;
            r_pending <= 4'b0000;
            r_mask    <= 4'b0000;
            r_irq_id  <= 2'd0;
            r_ret_pc  <= '0;
        end else begin
            r_irq_q   <= irq;
            // A fresh edge on the line being accepted outranks the clear.
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (mask_we) begin
                r_mask <= mask_in;
            end
            if (w_accept) begin
                r_irq_id <= w_winner;
            end
            if (r_state == ST_ACK) begin
                r_ret_pc <= pc_next;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        pc_load      = 1'b0;
        pc_vector    = '0;
        interruption = 1'b0;
        busy         = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                pc_load     = 1'b1;
                pc_vector   = w_vec;
                w_state_nxt = ST_SERVICE;
            end
            ST_SERVICE: begin
                interruption = 1'b1;
                // No preemption: only reti leaves service.
                if (reti) begin
                    w_state_nxt = ST_RETURN;
                end
            end
            ST_RETURN: begin
                pc_load      = 1'b1;
                pc_vector    = r_ret_pc;
                interruption = 1'b1;
                // Always back to IDLE; pending work is arbitrated from there.
                w_state_nxt  = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign irq_id  = r_irq_id;
    assign pending = r_pending;
    assign mask    = r_mask;

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;
    localparam int W = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   irq;
    logic         ien;
    logic         mask_we;
    logic [3:0]   mask_in;
    logic [W-1:0] pc_next;
    logic         reti;
    logic         pc_load;
    logic [W-1:0] pc_vector;
    logic         interruption;
    logic [1:0]   irq_id;
    logic [3:0]   pending;
    logic [3:0]   mask;
    logic         busy;

    intr_ctrl #(.WIDTH(W), .VEC_BASE(10'h3F0)) dut (
        .clk          (clk),
        .reset        (reset),
        .irq          (irq),
        .ien          (ien),
        .mask_we      (mask_we),
        .mask_in      (mask_in),
        .pc_next      (pc_next),
        .reti         (reti),
        .pc_load      (pc_load),
        .pc_vector    (pc_vector),
        .interruption (interruption),
        .irq_id       (irq_id),
        .pending      (pending),
        .mask         (mask),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] vec;
        logic [1:0]   id;
        logic         intr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [W-1:0] vec, input logic [1:0] id, input logic intr);
        exp_t e;
        e.vec  = vec;
        e.id   = id;
        e.intr = intr;
        exp_q.push_back(e);
    endtask

    // Advance n active edges; inputs change and direct checks sample 1 time unit later.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every PC load must match the next expected load.
    always @(negedge clk) begin
        exp_t e;
        if (pc_load === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pc_load: got vector %0h, expected no load", pc_vector);
            end else begin
                e = exp_q.pop_front();
                check("load_pc_vector", pc_vector, e.vec);
                check("load_irq_id", irq_id, e.id);
                check("load_interruption", interruption, e.intr);
            end
        end
    end

    initial begin
        reset = 1'b0; irq = 4'b0; ien = 1'b0; mask_we = 1'b0; mask_in = 4'b0;
        pc_next = '0; reti = 1'b0;
        step(2);
        check("rst_pc_load", pc_load, 0);
        check("rst_pc_vector", pc_vector, 0);
        check("rst_interruption", interruption, 0);
        check("rst_irq_id", irq_id, 0);
        check("rst_pending", pending, 0);
        check("rst_mask", mask, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;

        // Basic entry on irq[2]
        mask_we = 1'b1; mask_in = 4'hF; ien = 1'b1; pc_next = 10'h055;
        step(1);
        mask_we = 1'b0;
        check("mask_loaded", mask, 4'hF);
        push(10'h3F8, 2'd2, 1'b0);
        irq = 4'b0100;
        step(1);
        check("s1_pending_set", pending, 4'b0100);
        check("s1_idle_before_ack", busy, 0);
        step(1);                                  // ACK
        check("s1_ack_busy", busy, 1);
        check("s1_pending_cleared", pending, 0);
        step(1);                                  // SERVICE
        check("s1_service_intr", interruption, 1);
        check("s1_irq_id", irq_id, 2);
        check("s1_service_no_load", pc_load, 0);
        push(10'h055, 2'd2, 1'b1);
        reti = 1'b1;
        step(1);                                  // RETURN
        reti = 1'b0;
        step(1);                                  // IDLE
        check("s1_back_idle", busy, 0);
        check("s1_idle_intr", interruption, 0);
        irq = 4'b0;
        step(1);

        // Priority: irq[3] and irq[1] together
        pc_next = 10'h123;
        push(10'h3F4, 2'd1, 1'b0);
        irq = 4'b1010;
        step(1);
        check("s2_pending_both", pending, 4'b1010);
        step(1);                                  // ACK irq1
        check("s2_pending3_held", pending, 4'b1000);
        step(1);                                  // SERVICE
        check("s2_irq_id1", irq_id, 1);
        push(10'h123, 2'd1, 1'b1);
        reti = 1'b1;
        step(1);                                  // RETURN
        reti = 1'b0;
        check("s2_return_intr", interruption, 1);
        step(1);                                  // IDLE despite pending
        check("s2_idle_after_return", busy, 0);
        check("s2_pending3_still", pending, 4'b1000);
        push(10'h3FC, 2'd3, 1'b0);
        step(1);                                  // ACK irq3
        step(1);                                  // SERVICE
        check("s2_irq_id3", irq_id, 3);
        push(10'h123, 2'd3, 1'b1);
        reti = 1'b1;
        step(1);
        reti = 1'b0;
        step(1);
        irq = 4'b0;
        step(1);

        // Masking
        pc_next = 10'h2AA;
        mask_we = 1'b1; mask_in = 4'b1110;
        step(1);
        mask_we = 1'b0;
        irq = 4'b0001;
        step(3);
        check("s3_masked_pending", pending, 4'b0001);
        check("s3_masked_no_ack", busy, 0);
        push(10'h3F0, 2'd0, 1'b0);
        mask_we = 1'b1; mask_in = 4'hF;
        step(1);                                  // mask now F, still IDLE
        mask_we = 1'b0;
        check("s3_ack_not_yet", busy, 0);
        step(1);                                  // ACK
        step(1);                                  // SERVICE
        check("s3_irq_id0", irq_id, 0);
        check("s3_pending_clear", pending, 0);

        // No nesting: irq[0] re-rises in SERVICE, ien toggled
        irq = 4'b0000;
        step(1);
        irq = 4'b0001; ien = 1'b0;
        step(1);
        ien = 1'b1;
        step(1);
        check("s4_still_service", interruption, 1);
        check("s4_still_busy", busy, 1);
        check("s4_pending0", pending, 4'b0001);
        push(10'h2AA, 2'd0, 1'b1);
        reti = 1'b1;
        step(1);                                  // RETURN
        reti = 1'b0;
        step(1);                                  // IDLE
        check("s4_idle", busy, 0);
        check("s4_pending0_idle", pending, 4'b0001);
        push(10'h3F0, 2'd0, 1'b0);
        step(1);                                  // ACK
        step(1);                                  // SERVICE
        check("s4_pending_clear", pending, 0);

        // Reset in SERVICE with pending[3]
        irq = 4'b1001;
        step(1);
        check("s5_pending3", pending, 4'b1000);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        check("s5_rst_busy", busy, 0);
        check("s5_rst_pending", pending, 0);
        check("s5_rst_mask", mask, 0);
        check("s5_rst_intr", interruption, 0);
        check("s5_rst_pc_load", pc_load, 0);
        check("s5_rst_irq_id", irq_id, 0);
        check("s5_rst_pc_vector", pc_vector, 0);
        reti = 1'b1;
        step(1);
        reti = 1'b0;
        check("s5_held_lines_pending", pending, 4'b1001);
        step(2);
        check("s5_reti_ignored", busy, 0);

        // ien gating, then drain pending[0] and pending[3]
        ien = 1'b0; mask_we = 1'b1; mask_in = 4'hF;
        step(1);
        mask_we = 1'b0;
        step(2);
        check("s6_ien_gate", busy, 0);
        pc_next = 10'h3FF;
        push(10'h3F0, 2'd0, 1'b0);
        ien = 1'b1;
        step(1);                                  // ACK irq0
        step(1);                                  // SERVICE
        check("s6_irq_id0", irq_id, 0);
        check("s6_pending3", pending, 4'b1000);
        push(10'h3FF, 2'd0, 1'b1);
        reti = 1'b1;
        step(1);
        reti = 1'b0;
        step(1);                                  // IDLE
        push(10'h3FC, 2'd3, 1'b0);
        step(1);                                  // ACK irq3
        step(1);                                  // SERVICE
        push(10'h3FF, 2'd3, 1'b1);
        reti = 1'b1;
        step(1);
        reti = 1'b0;
        step(1);
        irq = 4'b0;
        step(3);
        check("final_idle", busy, 0);
        check("expected_loads_left", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
